// File: rtl/fetch_unit_pkg.sv
// Shared ISA constants, fetch FSM encoding and the fetch buffer entry layout.
package fetch_unit_pkg;
  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013; // ADDI x0,x0,0
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {insn, pc}; clear wins over push.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   count;
  logic         do_push, do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem reads, 2-deep buffer, ir/pc1 output
// register with redirect/flush handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc1,
  output logic        flush
);
  fetch_state_e state, state_nx;
  logic [31:0]  fetch_pc, req_addr;
  logic         buf_full, buf_empty, buf_push, buf_pop;
  fetch_entry_t buf_head, buf_din;

  // rst_n gating keeps imem_req low while reset is held.
  assign imem_req  = rst_n && (state == IDLE) && !buf_full && !redirect;
  assign imem_addr = fetch_pc;
  assign buf_push  = (state == WAIT) && imem_valid && !redirect;
  assign buf_pop   = !redirect && !stall && !buf_empty;
  assign buf_din   = '{insn: imem_rdata, pc: req_addr};

  fetch_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .pop   (buf_pop),
    .clear (redirect),
    .din   (buf_din),
    .dout  (buf_head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (imem_req) state_nx = WAIT;
      // A response landing with the redirect completes the read; don't wait for another.
      WAIT:      if (imem_valid) state_nx = IDLE;
                 else if (redirect) state_nx = WAIT_KILL;
      WAIT_KILL: if (imem_valid) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      ir       <= NOP_INSN;
      pc1      <= RESET_PC;
      flush    <= 1'b0;
    end else begin
      state <= state_nx;
      flush <= redirect;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~32'h3;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_addr <= fetch_pc;
      end
      if (redirect) begin
        ir <= NOP_INSN;
      end else if (!stall) begin
        if (!buf_empty) begin
          ir  <= buf_head.insn;
          pc1 <= buf_head.pc;
        end else begin
          ir  <= NOP_INSN;
        end
      end
    end
  end
endmodule
